// File: rtl/lut_mult_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lut_mult_accum_pkg
// Description : Shared types and helpers for the product accumulator.
//               Provides the two-state FSM encoding, the result term-count
//               width and a ceil(log2) helper for sizing the accumulator
//               against the frame length.
// Revision    : 1.0  initial release
// ============================================================================
package lut_mult_accum_pkg;

    // Width of the out_count term counter (frames are 1..255 products)
    localparam int COUNT_WIDTH = 8;

    // Accumulate products until the frame closes, then hold the result
    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lut_mult_accum.sv
`default_nettype none
// ============================================================================
// Module      : lut_mult_accum
// Description : Accumulate half of a constant-coefficient MAC. Sums up to
//               ACC_COUNT unsigned products (fewer when in_last closes the
//               frame early) and presents sum and term count on a
//               valid/ready output, holding them until taken. Input is
//               stalled while a result waits.
// Ports       : clk        rising-edge clock
//               rst        asynchronous active-high reset
//               in_valid   in_prod/in_last valid
//               in_ready   product can be accepted this cycle
//               in_prod    unsigned product [PROD_WIDTH]
//               in_last    this beat closes the frame early
//               out_valid  out_sum/out_count valid
//               out_ready  consumer takes the result this cycle
//               out_sum    frame sum [ACC_WIDTH]
//               out_count  number of products in the frame [8]
// Revision    : 1.0  initial release
// ============================================================================
module lut_mult_accum
    import lut_mult_accum_pkg::*;
#(
    parameter int PROD_WIDTH = 16,
    parameter int ACC_COUNT  = 4,
    parameter int ACC_WIDTH  = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PROD_WIDTH-1:0]  in_prod,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_sum,
    output logic [COUNT_WIDTH-1:0] out_count
);

    // Counter value of the final beat of a full frame
    localparam logic [COUNT_WIDTH-1:0] c_LAST_CNT = COUNT_WIDTH'(ACC_COUNT - 1);

    state_t                 r_state;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [ACC_WIDTH-1:0]   r_out_sum;
    logic [COUNT_WIDTH-1:0] r_out_count;

    logic                   w_accept;
    logic                   w_close;
    logic [ACC_WIDTH-1:0]   w_sum;
    logic [COUNT_WIDTH-1:0] w_cnt_inc;

    // r_in_ready is low only in DONE and during reset, so gating on it alone
    // also keeps the block deaf until the first edge after reset release.
    assign w_accept  = in_valid && r_in_ready;
    assign w_close   = (r_cnt == c_LAST_CNT) || in_last;
    assign w_sum     = r_acc + ACC_WIDTH'(in_prod);
    assign w_cnt_inc = r_cnt + COUNT_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    if (w_accept) begin
                        if (w_close) begin
                            r_out_sum   <= w_sum;
                            r_out_count <= w_cnt_inc;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_state     <= ST_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_ACCUM;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_lut_mult_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut_mult_accum
// Description : Self-checking bench for lut_mult_accum (ACC_COUNT=4,
//               ACC_WIDTH=18). Products come from a behavioural model of a
//               constant multiplier; a reference model pushes each expected
//               frame result into a scoreboard queue, and a monitor pops and
//               compares whenever the DUT hands a result off.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lut_mult_accum;

    localparam int c_PW   = 16;
    localparam int c_AC   = 4;
    localparam int c_AW   = 18;
    localparam int c_WAIT = 50;

    typedef struct packed {
        logic [c_AW-1:0] sum;
        logic [7:0]      count;
    } result_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [c_PW-1:0] in_prod;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [c_AW-1:0] out_sum;
    logic [7:0]      out_count;

    result_t         sb[$];
    logic [c_AW-1:0] m_acc;
    int              m_cnt;
    int              n_checks;
    int              n_pass;
    int              n_results;

    lut_mult_accum #(
        .PROD_WIDTH (c_PW),
        .ACC_COUNT  (c_AC),
        .ACC_WIDTH  (c_AW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Result monitor: a handoff happens at the next rising edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_result_count", 32'(sb.size()), 32'd1);
            end else begin
                result_t e;
                e = sb.pop_front();
                check("out_sum", 32'(out_sum), 32'(e.sum));
                check("out_count", 32'(out_count), 32'(e.count));
                n_results = n_results + 1;
            end
        end
    end

    // Drive one product a*x; returns once the DUT accepts it
    task automatic send(input logic [7:0] a, input logic [7:0] x, input logic last);
        int       waited;
        logic [15:0] p;
        logic     closed;
        p        = {8'd0, a} * {8'd0, x};
        waited   = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < c_WAIT) begin
            @(negedge clk);
            waited = waited + 1;
        end
        if (!in_ready) begin
            check("in_ready_wait_cycles", 32'(waited), 32'(c_WAIT - 1));
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_acc    = m_acc + c_AW'(p);
        m_cnt    = m_cnt + 1;
        closed   = (m_cnt == c_AC) || last;
        if (closed) begin
            sb.push_back('{sum: m_acc, count: 8'(m_cnt)});
            m_acc = '0;
            m_cnt = 0;
        end
        // Result must be visible the cycle after the closing beat
        check("valid_after_beat", 32'(out_valid), 32'(closed));
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < c_WAIT) begin
            @(posedge clk);
            #1;
            waited = waited + 1;
        end
        check("pending_results", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        result_t held;
        n_checks  = 0;
        n_pass    = 0;
        n_results = 0;
        m_acc     = '0;
        m_cnt     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // 1. Full frame back-to-back, a=2, x=0..3 -> 12
        for (int i = 0; i < 4; i++) send(8'd2, 8'(i), 1'b0);
        drain();

        // 2. Early end on the second beat -> 24, count 2
        send(8'd2, 8'd5, 1'b0);
        send(8'd2, 8'd7, 1'b1);
        drain();

        // 3. Backpressure for 5 cycles, with a stray beat offered meanwhile
        out_ready = 1'b0;
        send(8'd3, 8'd10, 1'b0);
        send(8'd3, 8'd11, 1'b0);
        send(8'd3, 8'd12, 1'b1);
        held     = sb[0];
        in_valid = 1'b1;
        in_prod  = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_sum", 32'(out_sum), 32'(held.sum));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b1;
        drain();
        check("bp_results_so_far", 32'(n_results), 32'd3);

        // 4. Bubbles between every beat, a=2, x=1..4 -> 20
        for (int i = 1; i <= 4; i++) begin
            send(8'd2, 8'(i), 1'b0);
            bubble(2);
        end
        drain();

        // 5. Max value: 255*255 x4 -> 260100, in_last on the 4th beat
        for (int i = 0; i < 4; i++) send(8'd255, 8'd255, i == 3);
        drain();

        // 6a. Reset mid-frame after two beats
        send(8'd9, 8'd9, 1'b0);
        send(8'd9, 8'd9, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        m_acc = '0;
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(8'd1, 8'd1, 1'b0);
        drain();

        // 6b. Reset while a result is held: output must drop at once
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'd4, 8'd4, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("donerst_out_valid", 32'(out_valid), 32'd0);
        check("donerst_out_sum", 32'(out_sum), 32'd0);
        sb.delete();
        m_acc = '0;
        m_cnt = 0;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(8'd6, 8'd7, 1'b1);
        drain();
        check("total_results", 32'(n_results), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
